result_streamer: RTL and testbench
==================================

# result_streamer

Reads the 1-bit binarized result memory in raster order once the global state machine reaches the output phase. Packs eight pixels per byte, MSB-first, and delivers bytes over a valid/ready stream to the host-side transmitter. Sits downstream of the thresholding stage on the read port of the result memory, and raises `finished` when the frame has been fully delivered.

## Interface
- `WIDTH_BITS`, 8: column address width; must be ≥ 3.
- `HEIGHT_BITS`, 8: row address width.
- `WIDTH`, 2**WIDTH_BITS: image width in pixels.
- `HEIGHT`, 2**HEIGHT_BITS: image height in pixels.
- `RUN_STATE`, 3: value of `global_state` that enables streaming.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `oResultCol` out WIDTH_BITS: result-memory read column.
- `oResultRow` out HEIGHT_BITS: result-memory read row.
- `iResultData` in 1: read data; registered memory, so valid one cycle after the address.
- `global_state` in 3: system phase.
- `oByte` out 8: packed pixels; bit7 is the lowest column of the group.
- `oValid` out 1: `oByte` is valid.
- `iReady` in 1: consumer accepts the byte; a transfer occurs when `oValid && iReady`.
- `finished` out 1: sticky; the last byte has been accepted.

## Operation
- States:
  - IDLE: waits for `global_state == RUN_STATE`.
  - FETCH: issues reads and packs pixels.
  - DRAIN: all pixels issued, final byte pending.
  - DONE: end of frame.
- IDLE → FETCH when `global_state == RUN_STATE`. The address for pixel 0 is presented in that cycle.
- FETCH:
  - Each cycle presents the address of pixel p and captures the data for pixel p−1 from the previous cycle.
  - A 3-bit counter tracks the bit position within the current byte.
  - Bit positions 0–6: shift the captured pixel into the shift register and advance.
  - Bit position 7, output slot free (`!oValid || iReady`): load `oByte <= {shift[6:0], iResultData}`, set `oValid`, advance.
  - Bit position 7, slot occupied: stall. Do not capture and do not advance. Re-present the bit-7 pixel's address so `iResultData` stays valid next cycle.
- After the address of pixel WIDTH*HEIGHT−1 is issued → DRAIN. DRAIN completes the final capture under the same stall rule.
- DONE is entered when the final byte is accepted: set `finished` and drop `oValid`. The block stays in DONE until reset.
- `oValid` clears on handshake unless a new byte loads in the same cycle. Simultaneous accept and load leaves `oValid` high with the new byte.
- `global_state != RUN_STATE` while in FETCH/DRAIN:
  - Fetching pauses: address held, no capture.
  - A pending `oByte`/`oValid` may still be accepted.
  - Resumes without data loss when the state returns.
- Address arithmetic: linear index of WIDTH_BITS+HEIGHT_BITS bits. Low bits are the column, high bits the row. No wrap past the last pixel.

## Timing
- Reset values:
  - `oByte` = 0, `oValid` = 0, `finished` = 0.
  - `oResultCol` = 0, `oResultRow` = 0.
  - State IDLE, bit counter 0.
  - `oFirst` = 0 and `oLast` = 0 when present.
- `reset` mid-frame aborts immediately. Outputs return to reset values and the next run restarts at pixel 0.
- Latency: first `oValid` rises 9 cycles after FETCH entry (8 addresses plus 1 read latency).
- Throughput: 1 byte per 8 cycles with `iReady` held high; no bubbles between bytes.
- `oByte` is stable while `oValid && !iReady`.
- `finished` rises the cycle after the last handshake.

## Configuration
- `RESULT_STREAMER_FRAME_MARKER_EN` defined:
  - Adds ports `oFirst` and `oLast` (out, 1 bit each), registered alongside `oByte`.
  - `oFirst` is high with byte 0 only.
  - `oLast` is high with the final byte only.
  - Both are 1 for a single-byte frame.
- Undefined: neither port exists, and there is no other behavioural difference.

## Structure
- Package `result_streamer_pkg` holds:
  - the state enum (IDLE, FETCH, DRAIN, DONE);
  - `PIXELS_PER_BYTE = 8`;
  - the default `RUN_STATE` constant.
- Sub-module `result_bit_packer` holds the shift register, the bit counter and the output byte/valid register with the handshake. The top level holds the FSM and address generation.

## Test plan
Bench: `WIDTH_BITS = 3`, `HEIGHT_BITS = 1` (16 pixels, 2 bytes), behavioural 1-cycle-latency memory.
- Memory 1,0,1,1,0,0,0,1 / 0,1,1,1,1,1,1,0; `iReady` = 1; `global_state` 0→3 → bytes 0xB1 then 0x7E; first `oValid` 9 cycles after the 0→3 transition; `finished` = 1 one cycle after the second handshake.
- Same image, `iReady` = 0 for 20 cycles after the first `oValid` → `oByte` holds 0xB1; the address stalls on pixel 15; after release, 0x7E arrives intact.
- `global_state` drops to 2 for 5 cycles mid-byte → no pixel lost or duplicated; output still 0xB1, 0x7E.
- `reset` pulsed after 4 cycles of FETCH, then restart → all outputs at reset values; the full stream repeats correctly from 0xB1.
- Macro defined → `oFirst` high only with 0xB1 and `oLast` high only with 0x7E; with the macro undefined, the module compiles without those ports.
- `iReady` toggling every cycle → exactly 2 handshakes; `finished` sticky thereafter; no further memory reads after DONE.

Source files
------------

// File: rtl/result_streamer_pkg.sv
// result_streamer_pkg: shared types and constants for the result streamer.
package result_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int         PIXELS_PER_BYTE   = 8;
    localparam logic [2:0] RUN_STATE_DEFAULT = 3'd3;

endpackage

// File: rtl/result_streamer_if.sv
// result_streamer_if: byte stream from the streamer to the host-side transmitter.
// Optional frame markers exist only when RESULT_STREAMER_FRAME_MARKER_EN is defined.
interface result_streamer_if;
    logic [7:0] oByte;
    logic       oValid;
    logic       iReady;
`ifdef RESULT_STREAMER_FRAME_MARKER_EN
    logic       oFirst;
    logic       oLast;
`endif

    modport master (
        input  iReady,
        output oByte,
        output oValid
`ifdef RESULT_STREAMER_FRAME_MARKER_EN
        ,
        output oFirst,
        output oLast
`endif
    );

    modport slave (
        output iReady,
        input  oByte,
        input  oValid
`ifdef RESULT_STREAMER_FRAME_MARKER_EN
        ,
        input  oFirst,
        input  oLast
`endif
    );
endinterface

// File: rtl/result_bit_packer.sv
// result_bit_packer: packs captured pixels MSB-first into bytes and owns the
// output byte/valid register. A byte is only completed when the output slot is
// free, so the caller stalls on the eighth pixel instead of losing it.
// Frame markers are built when RESULT_STREAMER_FRAME_MARKER_EN is defined.
module result_bit_packer
    import result_streamer_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic data_ok_i,     // iResultData holds a pixel that may be captured
    input  logic bit_i,
`ifdef RESULT_STREAMER_FRAME_MARKER_EN
    input  logic last_i,        // the pixel being captured belongs to the final byte
`endif
    output logic take_o,        // pixel captured this cycle
    result_streamer_if.master strm
);

    localparam logic [2:0] LAST_BIT = 3'(PIXELS_PER_BYTE - 1);

    logic [2:0] cnt_q, cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic       valid_q, valid_d;
    logic       slot_free;
    logic       load;

    assign slot_free = !valid_q || strm.iReady;
    assign take_o    = data_ok_i && ((cnt_q != LAST_BIT) || slot_free);
    assign load      = take_o && (cnt_q == LAST_BIT);

    // Next-state for the shift register, bit counter and output slot.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = valid_q;
        if (valid_q && strm.iReady) valid_d = 1'b0;
        if (take_o) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q != LAST_BIT) shift_d = {shift_q[5:0], bit_i};
        end
        if (load) begin
            byte_d  = {shift_q, bit_i};
            valid_d = 1'b1;
        end
    end

    // Packer registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
        end
    end

    assign strm.oByte  = byte_q;
    assign strm.oValid = valid_q;

`ifdef RESULT_STREAMER_FRAME_MARKER_EN
    logic first_pend_q, first_q, last_q;

    // Markers load together with the byte; the first-byte flag is consumed once.
    always_ff @(posedge clock) begin
        if (reset) begin
            first_pend_q <= 1'b1;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
        end else if (load) begin
            first_pend_q <= 1'b0;
            first_q      <= first_pend_q;
            last_q       <= last_i;
        end
    end

    assign strm.oFirst = first_q;
    assign strm.oLast  = last_q;
`endif

endmodule

// File: rtl/result_streamer.sv
// result_streamer: reads the binarized result memory in raster order and
// streams it as MSB-first packed bytes. Frame markers (oFirst/oLast) are added
// when RESULT_STREAMER_FRAME_MARKER_EN is defined.
//
// state | meaning
// IDLE  | waiting for global_state == RUN_STATE, pixel 0 address presented
// FETCH | issuing addresses and capturing the previous pixel
// DRAIN | last address issued, final capture / final byte pending
// DONE  | frame delivered, finished held until reset
module result_streamer
    import result_streamer_pkg::*;
#(
    parameter int         WIDTH_BITS  = 8,
    parameter int         HEIGHT_BITS = 8,
    parameter logic [2:0] RUN_STATE   = RUN_STATE_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [WIDTH_BITS-1:0]  oResultCol,
    output logic [HEIGHT_BITS-1:0] oResultRow,
    input  logic                   iResultData,
    input  logic [2:0]             global_state,
    output logic                   finished,
    result_streamer_if.master      strm
);

    localparam int IDX_BITS = WIDTH_BITS + HEIGHT_BITS;
    localparam int WIDTH    = 2 ** WIDTH_BITS;
    localparam int HEIGHT   = 2 ** HEIGHT_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(WIDTH * HEIGHT - 1);
    localparam logic [IDX_BITS-1:0] IDX_ONE  = IDX_BITS'(1);

    state_e              state_q, state_d;
    logic [IDX_BITS-1:0] pix_q, pix_d;     // next address to issue
    logic [IDX_BITS-1:0] addr;
    logic                last_cap_q, last_cap_d;
    logic                finished_q, finished_d;
    logic                run;
    logic                data_ok;
    logic                take;

    assign run     = (global_state == RUN_STATE);
    assign data_ok = run && ((state_q == ST_FETCH) ||
                             (state_q == ST_DRAIN && !last_cap_q));

    result_bit_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .data_ok_i (data_ok),
        .bit_i     (iResultData),
`ifdef RESULT_STREAMER_FRAME_MARKER_EN
        .last_i    (state_q == ST_DRAIN),
`endif
        .take_o    (take),
        .strm      (strm)
    );

    // When no capture happens in FETCH, re-present the pixel whose data is
    // pending so the registered memory still returns it next cycle.
    always_comb begin
        addr = pix_q;
        if (state_q == ST_FETCH && !take) addr = pix_q - IDX_ONE;
    end

    assign oResultCol = addr[WIDTH_BITS-1:0];
    assign oResultRow = addr[IDX_BITS-1:WIDTH_BITS];
    assign finished   = finished_q;

    // Next-state logic: phase sequencing and address advance.
    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        last_cap_d = last_cap_q;
        finished_d = finished_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                    pix_d   = IDX_ONE;
                end
            end
            ST_FETCH: begin
                if (take) begin
                    if (pix_q == LAST_IDX) state_d = ST_DRAIN;
                    else                   pix_d   = pix_q + IDX_ONE;
                end
            end
            ST_DRAIN: begin
                if (take) last_cap_d = 1'b1;
                if (last_cap_q && strm.oValid && strm.iReady) begin
                    state_d    = ST_DONE;
                    finished_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State and address registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pix_q      <= '0;
            last_cap_q <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            last_cap_q <= last_cap_d;
            finished_q <= finished_d;
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// tb_result_streamer: directed bench for result_streamer on a 8x2 image with a
// scoreboard of expected bytes and a behavioural 1-cycle-latency memory.
module tb_result_streamer;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] oResultCol;
    logic [0:0] oResultRow;
    logic       iResultData;
    logic [2:0] global_state;
    logic       finished;

    result_streamer_if strm_if ();

    result_streamer #(
        .WIDTH_BITS  (3),
        .HEIGHT_BITS (1),
        .RUN_STATE   (3'd3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .oResultCol   (oResultCol),
        .oResultRow   (oResultRow),
        .iResultData  (iResultData),
        .global_state (global_state),
        .finished     (finished),
        .strm         (strm_if)
    );

    always #5 clock = ~clock;

    logic mem [0:15];
    always @(posedge clock) iResultData <= mem[{oResultRow, oResultCol}];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_count = 0;
    int hs_cyc = 0;
    int byte_idx = 0;
    logic fin_at_hs = 1'b0;
    logic [7:0] exp_q [$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every transfer is compared against the queue head.
    always @(negedge clock) begin
        if (!reset && strm_if.oValid && strm_if.iReady) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_byte observed=%0h expected=none", strm_if.oByte);
            end else begin
                check("byte", {24'd0, strm_if.oByte}, {24'd0, exp_q.pop_front()});
            end
`ifdef RESULT_STREAMER_FRAME_MARKER_EN
            check("first", {31'd0, strm_if.oFirst}, {31'd0, byte_idx == 0});
            check("last", {31'd0, strm_if.oLast}, {31'd0, byte_idx == 1});
`endif
            byte_idx++;
            hs_count++;
            hs_cyc = cyc;
            fin_at_hs = finished;
        end
    end

    function automatic logic [7:0] model_byte(input int b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = mem[b*8 + i];
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic load_image1();
        logic [15:0] img;
        img = 16'b1011_0001_0111_1110;
        for (int i = 0; i < 16; i++) mem[i] = img[15-i];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        global_state = 3'd0;
        tick(2);
        reset = 1'b0;
        hs_count = 0;
        byte_idx = 0;
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, {31'd0, strm_if.oValid}, 32'd0);
        check({tag, "_byte"}, {24'd0, strm_if.oByte}, 32'd0);
        check({tag, "_finished"}, {31'd0, finished}, 32'd0);
        check({tag, "_col"}, {29'd0, oResultCol}, 32'd0);
        check({tag, "_row"}, {31'd0, oResultRow}, 32'd0);
`ifdef RESULT_STREAMER_FRAME_MARKER_EN
        check({tag, "_first"}, {31'd0, strm_if.oFirst}, 32'd0);
        check({tag, "_lastm"}, {31'd0, strm_if.oLast}, 32'd0);
`endif
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!strm_if.oValid && n < 60) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!finished && n < 400) begin
            tick(1);
            n++;
        end
        check({tag, "_finished"}, {31'd0, finished}, 32'd1);
        check({tag, "_fin_low_at_hs"}, {31'd0, fin_at_hs}, 32'd0);
        check({tag, "_fin_timing"}, cyc, hs_cyc + 1);
        check({tag, "_handshakes"}, hs_count, 32'd2);
        check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        int n;
        logic [3:0] addr_done;

        reset = 1'b1;
        global_state = 3'd0;
        strm_if.iReady = 1'b1;
        load_image1();
        tick(3);
        check_reset_values("reset");
        reset = 1'b0;
        tick(2);
        check("idle_valid", {31'd0, strm_if.oValid}, 32'd0);

        // Run 1: plain stream with iReady high.
        exp_q.push_back(8'hB1);
        exp_q.push_back(8'h7E);
        global_state = 3'd3;
        wait_valid(n);
        check("run1_latency", n, 32'd9);
        check("run1_first_byte", {24'd0, strm_if.oByte}, 32'hB1);
        wait_done("run1");
        addr_done = {oResultRow, oResultCol};
        tick(10);
        check("run1_addr_hold", {28'd0, oResultRow, oResultCol}, {28'd0, addr_done});
        check("run1_sticky", {31'd0, finished}, 32'd1);
        check("run1_valid_low", {31'd0, strm_if.oValid}, 32'd0);

        // Run 2: consumer backpressure for 20 cycles.
        do_reset();
        exp_q.push_back(8'hB1);
        exp_q.push_back(8'h7E);
        strm_if.iReady = 1'b0;
        global_state = 3'd3;
        wait_valid(n);
        check("run2_latency", n, 32'd9);
        for (int i = 0; i < 20; i++) begin
            check("run2_hold_byte", {24'd0, strm_if.oByte}, 32'hB1);
            tick(1);
        end
        check("run2_hold_valid", {31'd0, strm_if.oValid}, 32'd1);
        check("run2_stall_addr", {28'd0, oResultRow, oResultCol}, 32'd15);
        strm_if.iReady = 1'b1;
        wait_done("run2");

        // Run 3: global_state leaves the run phase for 5 cycles mid-byte.
        do_reset();
        exp_q.push_back(8'hB1);
        exp_q.push_back(8'h7E);
        global_state = 3'd3;
        tick(4);
        global_state = 3'd2;
        tick(5);
        check("run3_paused_valid", {31'd0, strm_if.oValid}, 32'd0);
        global_state = 3'd3;
        wait_valid(n);
        check("run3_latency_rest", n, 32'd5);
        wait_done("run3");

        // Run 4: reset after 4 cycles of FETCH, then a full restart.
        do_reset();
        exp_q.push_back(8'hB1);
        global_state = 3'd3;
        tick(5);
        reset = 1'b1;
        global_state = 3'd0;
        tick(1);
        check_reset_values("midreset");
        reset = 1'b0;
        exp_q.delete();
        hs_count = 0;
        byte_idx = 0;
        tick(1);
        exp_q.push_back(8'hB1);
        exp_q.push_back(8'h7E);
        global_state = 3'd3;
        wait_valid(n);
        check("run4_latency", n, 32'd9);
        wait_done("run4");

        // Run 5: random image, iReady toggling every cycle.
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = 1'($urandom_range(0, 1));
        exp_q.push_back(model_byte(0));
        exp_q.push_back(model_byte(1));
        global_state = 3'd3;
        n = 0;
        while (!finished && n < 400) begin
            strm_if.iReady = ~strm_if.iReady;
            tick(1);
            n++;
        end
        check("run5_finished", {31'd0, finished}, 32'd1);
        check("run5_handshakes", hs_count, 32'd2);
        check("run5_queue_empty", exp_q.size(), 32'd0);
        addr_done = {oResultRow, oResultCol};
        for (int i = 0; i < 10; i++) begin
            strm_if.iReady = ~strm_if.iReady;
            tick(1);
        end
        check("run5_sticky", {31'd0, finished}, 32'd1);
        check("run5_no_reads", {28'd0, oResultRow, oResultCol}, {28'd0, addr_done});
        check("run5_handshakes_after", hs_count, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
